elastic_cgra_config_loader: RTL

Array-level controller that loads per-context configuration words into the elastic PEs and sequences their execution. It accepts a valid/ready stream of configuration words, drives the shared PE configuration bus, and strobes one PE at a time. After the last word it pulses `start_exec` to all PEs. It then supervises the run with a cycle budget and abort, and reports completion.

---
 rtl/elastic_cgra_config_loader_pkg.sv | 33 +++
 rtl/elastic_cgra_config_loader_config_stream_sequencer.sv | 84 ++++++++
 rtl/elastic_cgra_config_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/elastic_cgra_config_loader_pkg.sv
// Shared constants, state encoding and the PE configuration word layout
// for the elastic CGRA configuration loader.
package elastic_cgra_config_loader_pkg;

  localparam int INPUT_NUM_BIT_LENGTH    = 3;
  localparam int NEIGHBOR_PE_NUM         = 4;
  localparam int OPERATION_BIT_LENGTH    = 5;
  localparam int DATA_WIDTH              = 16;
  localparam int CONTEXT_SIZE            = 6;
  localparam int CONTEXT_SIZE_BIT_LENGTH = 3;

  localparam int PE_NUM_DEFAULT              = 16;
  localparam int PE_INDEX_BIT_LENGTH_DEFAULT = 4;

  // Field order matches the broadcast bus; the whole word moves as one register.
  typedef struct packed {
    logic [INPUT_NUM_BIT_LENGTH-1:0] input_PE_index_1;
    logic [INPUT_NUM_BIT_LENGTH-1:0] input_PE_index_2;
    logic [NEIGHBOR_PE_NUM-1:0]      output_PE_index;
    logic [OPERATION_BIT_LENGTH-1:0] op;
    logic [DATA_WIDTH-1:0]           const_data;
  } ElasticConfigData;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_START = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } loader_state_e;

endpackage

// File: rtl/elastic_cgra_config_loader_config_stream_sequencer.sv
// LOAD-phase word sequencer: accepts config words, walks pe/ctx in PE-major
// order and registers the broadcast bus plus a one-hot per-PE write strobe.
module config_stream_sequencer
  import elastic_cgra_config_loader_pkg::*;
#(
  parameter int PE_NUM              = PE_NUM_DEFAULT,
  parameter int PE_INDEX_BIT_LENGTH = PE_INDEX_BIT_LENGTH_DEFAULT
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               load_active_i,
  input  logic                               clear_i,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] ctx_max_i,
  input  logic                               cfg_valid_i,
  input  ElasticConfigData                   cfg_word_i,
  output logic                               cfg_ready_o,
  output ElasticConfigData                   bus_o,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index_o,
  output logic [PE_NUM-1:0]                  write_strobe_o,
  output logic                               last_accept_o
);

  logic [PE_INDEX_BIT_LENGTH-1:0]     pe_q, pe_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] ctx_q, ctx_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] index_q, index_d;
  logic [PE_NUM-1:0]                  strobe_q, strobe_d;
  ElasticConfigData                   bus_q, bus_d;

  logic accept;
  logic ctx_last;
  logic pe_last;

  assign cfg_ready_o   = load_active_i;
  assign accept        = cfg_valid_i && load_active_i;
  assign ctx_last      = (ctx_q == ctx_max_i);
  assign pe_last       = (pe_q == PE_INDEX_BIT_LENGTH'(PE_NUM - 1));
  assign last_accept_o = accept && pe_last && ctx_last;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    pe_d     = pe_q;
    ctx_d    = ctx_q;
    index_d  = index_q;
    bus_d    = bus_q;
    strobe_d = '0;
    if (clear_i) begin
      pe_d  = '0;
      ctx_d = '0;
    end else if (accept) begin
      bus_d    = cfg_word_i;
      index_d  = ctx_q;
      strobe_d = PE_NUM'(1) << pe_q;
      if (ctx_last) begin
        ctx_d = '0;
        pe_d  = pe_q + PE_INDEX_BIT_LENGTH'(1);
      end else begin
        ctx_d = ctx_q + CONTEXT_SIZE_BIT_LENGTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pe_q     <= '0;
      ctx_q    <= '0;
      index_q  <= '0;
      strobe_q <= '0;
      // NOTE: the bus is reset as well so PEs see all-zero fields out of reset.
      bus_q    <= '0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      pe_q     <= pe_d;
      ctx_q    <= ctx_d;
      index_q  <= index_d;
      strobe_q <= strobe_d;
      bus_q    <= bus_d;
    end
  end

  assign bus_o          = bus_q;
  assign config_index_o = index_q;
  assign write_strobe_o = strobe_q;

endmodule

// File: rtl/elastic_cgra_config_loader.sv
// Array-level loader: streams configuration into the PEs, starts execution,
// supervises the run with a cycle budget / abort and reports completion.
module elastic_cgra_config_loader
  import elastic_cgra_config_loader_pkg::*;
#(
  parameter int PE_NUM              = PE_NUM_DEFAULT,
  parameter int PE_INDEX_BIT_LENGTH = PE_INDEX_BIT_LENGTH_DEFAULT,
  parameter int RUN_COUNTER_WIDTH   = 32
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               load_request,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] context_max_id,
  input  logic [RUN_COUNTER_WIDTH-1:0]       run_cycle_limit,
  input  logic                               abort,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_PE_index_1,
  input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_PE_index_2,
  input  logic [NEIGHBOR_PE_NUM-1:0]         cfg_output_PE_index,
  input  logic [OPERATION_BIT_LENGTH-1:0]    cfg_op,
  input  logic [DATA_WIDTH-1:0]              cfg_const_data,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
  output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
  output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
  output logic [DATA_WIDTH-1:0]              config_const_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
  output logic [PE_NUM-1:0]                  write_config_data,
  output logic                               start_exec,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
  output logic                               busy,
  output logic                               exec_active,
  output logic                               done,
  output logic                               error
);

  localparam logic [RUN_COUNTER_WIDTH-1:0] RUN_CNT_MAX = '1;

  loader_state_e                      state_q, state_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_q, max_d;
  logic [RUN_COUNTER_WIDTH-1:0]       limit_q, limit_d;
  logic [RUN_COUNTER_WIDTH-1:0]       run_cnt_q, run_cnt_d;
  logic                               error_q, error_d;

  logic             req_ok;
  logic             load_clear;
  logic             last_accept;
  ElasticConfigData cfg_word;
  ElasticConfigData bus;

  assign req_ok     = int'(context_max_id) < CONTEXT_SIZE;
  assign load_clear = (state_q == S_IDLE) && load_request && req_ok;

  assign cfg_word = '{
    input_PE_index_1: cfg_input_PE_index_1,
    input_PE_index_2: cfg_input_PE_index_2,
    output_PE_index:  cfg_output_PE_index,
    op:               cfg_op,
    const_data:       cfg_const_data
  };

  config_stream_sequencer #(
    .PE_NUM              (PE_NUM),
    .PE_INDEX_BIT_LENGTH (PE_INDEX_BIT_LENGTH)
  ) u_seq (
    .clk            (clk),
    .reset_n        (reset_n),
    .load_active_i  (state_q == S_LOAD),
    .clear_i        (load_clear),
    .ctx_max_i      (max_q),
    .cfg_valid_i    (cfg_valid),
    .cfg_word_i     (cfg_word),
    .cfg_ready_o    (cfg_ready),
    .bus_o          (bus),
    .config_index_o (config_index),
    .write_strobe_o (write_config_data),
    .last_accept_o  (last_accept)
  );

  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    limit_d   = limit_q;
    run_cnt_d = run_cnt_q;
    error_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_request) begin
          if (req_ok) begin
            state_d   = S_LOAD;
            max_d     = context_max_id;
            limit_d   = run_cycle_limit;
            run_cnt_d = '0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_LOAD:  if (last_accept) state_d = S_FLUSH;
      S_FLUSH: state_d = S_START;
      S_START: begin
        run_cnt_d = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        // Saturate so an unbounded run never wraps back to a small count.
        if (run_cnt_q != RUN_CNT_MAX) run_cnt_d = run_cnt_q + RUN_COUNTER_WIDTH'(1);
        if (abort) begin
          state_d = S_DONE;
        end else if ((limit_q != '0) &&
                     (run_cnt_q == limit_q - RUN_COUNTER_WIDTH'(1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      max_q     <= '0;
      limit_q   <= '0;
      run_cnt_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      limit_q   <= limit_d;
      run_cnt_q <= run_cnt_d;
      error_q   <= error_d;
    end
  end

  assign config_input_PE_index_1 = bus.input_PE_index_1;
  assign config_input_PE_index_2 = bus.input_PE_index_2;
  assign config_output_PE_index  = bus.output_PE_index;
  assign config_op               = bus.op;
  assign config_const_data       = bus.const_data;

  assign start_exec             = (state_q == S_START);
  assign busy                   = (state_q != S_IDLE);
  assign exec_active            = (state_q == S_RUN);
  assign done                   = (state_q == S_DONE);
  assign error                  = error_q;
  assign mapping_context_max_id = max_q;

endmodule
